// File: rtl/test_pattern_sequencer.sv
// Multi-mode test-pattern source for hdmi_tx: colour bars, gradient, checker and
// bouncing box, selected by a frame-synchronous mode FSM with auto/manual advance.
module test_pattern_sequencer #(
  parameter int ACTIVE_W        = 720,
  parameter int ACTIVE_H        = 480,
  parameter int BAR_W           = 102,
  parameter int BOX_SIZE        = 32,
  parameter int BOX_STEP        = 2,
  parameter int FRAMES_PER_MODE = 120
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       inActiveDisplay,
  input  logic [9:0] hPosCounter,
  input  logic [9:0] vPosCounter,
  input  logic       holdMode,
  input  logic       nextMode,
  output logic [7:0] redByte,
  output logic [7:0] greenByte,
  output logic [7:0] blueByte,
  output logic [1:0] modeIndex,
  output logic       frameTick
);

  typedef enum logic [1:0] {
    S_BARS  = 2'd0,
    S_GRAD  = 2'd1,
    S_CHECK = 2'd2,
    S_BOX   = 2'd3
  } mode_t;

  localparam logic [9:0]  LP_H_LAST     = 10'(ACTIVE_W - 1);
  localparam logic [9:0]  LP_V_LAST     = 10'(ACTIVE_H - 1);
  localparam logic [9:0]  LP_X_LIM      = 10'(ACTIVE_W - BOX_SIZE);
  localparam logic [9:0]  LP_Y_LIM      = 10'(ACTIVE_H - BOX_SIZE);
  localparam logic [9:0]  LP_STEP10     = 10'(BOX_STEP);
  localparam logic [10:0] LP_STEP11     = 11'(BOX_STEP);
  localparam logic [10:0] LP_SIZE11     = 11'(BOX_SIZE);
  localparam logic [7:0]  LP_DWELL_LAST = 8'(FRAMES_PER_MODE - 1);
  localparam logic [10:0] LP_BAR1       = 11'(BAR_W);
  localparam logic [10:0] LP_BAR2       = 11'(2 * BAR_W);
  localparam logic [10:0] LP_BAR3       = 11'(3 * BAR_W);
  localparam logic [10:0] LP_BAR4       = 11'(4 * BAR_W);
  localparam logic [10:0] LP_BAR5       = 11'(5 * BAR_W);
  localparam logic [10:0] LP_BAR6       = 11'(6 * BAR_W);
  localparam logic [23:0] LP_WHITE      = 24'hFFFFFF;
  localparam logic [23:0] LP_BLACK      = 24'h000000;

  // One bounce step along an axis; result is {dir_next, pos_next}.
  function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                            input logic       dir,
                                            input logic [9:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, pos} + LP_STEP11;
    if (dir) begin
      if (sum >= {1'b0, lim}) res = {1'b0, lim};
      else                    res = {1'b1, sum[9:0]};
    end else begin
      if (pos <= LP_STEP10)   res = {1'b1, 10'd0};
      else                    res = {1'b0, pos - LP_STEP10};
    end
    return res;
  endfunction

  mode_t       r_mode, w_mode_next;
  logic [7:0]  r_dwell, w_dwell_next;
  logic        r_pending, w_pending_next;
  logic [7:0]  r_frameCount;
  logic [9:0]  r_boxX, r_boxY;
  logic        r_dirX, r_dirY;
  logic [23:0] r_rgb;
  logic        r_frameTick;
  logic        w_tick;
  logic        w_auto;
  logic [23:0] w_rgb;
  logic [10:0] w_stepX, w_stepY;
  logic [10:0] w_h11;
  logic        w_inX, w_inY;

  assign w_tick  = inActiveDisplay && (hPosCounter == LP_H_LAST) && (vPosCounter == LP_V_LAST);
  assign w_auto  = (r_dwell == LP_DWELL_LAST) && !holdMode;
  assign w_stepX = step_axis(r_boxX, r_dirX, LP_X_LIM);
  assign w_stepY = step_axis(r_boxY, r_dirY, LP_Y_LIM);

  // Mode FSM: state register
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_mode    <= S_BARS;
      r_dwell   <= 8'd0;
      r_pending <= 1'b0;
    end else begin
      r_mode    <= w_mode_next;
      r_dwell   <= w_dwell_next;
      r_pending <= w_pending_next;
    end
  end

  // Mode FSM: next state; a request on the tick cycle itself is serviced there
  always_comb begin
    w_mode_next    = r_mode;
    w_dwell_next   = r_dwell;
    w_pending_next = r_pending;
    if (w_tick) begin
      w_pending_next = 1'b0;
      if (r_pending || nextMode || w_auto) begin
        w_dwell_next = 8'd0;
        case (r_mode)
          S_BARS:  w_mode_next = S_GRAD;
          S_GRAD:  w_mode_next = S_CHECK;
          S_CHECK: w_mode_next = S_BOX;
          default: w_mode_next = S_BARS;
        endcase
      end else if (!holdMode) begin
        w_dwell_next = r_dwell + 8'd1;
      end
    end else if (nextMode) begin
      w_pending_next = 1'b1;
    end
  end

  assign w_h11 = {1'b0, hPosCounter};
  assign w_inX = (hPosCounter >= r_boxX) && (w_h11 < ({1'b0, r_boxX} + LP_SIZE11));
  assign w_inY = (vPosCounter >= r_boxY) && ({1'b0, vPosCounter} < ({1'b0, r_boxY} + LP_SIZE11));

  always_comb begin
    w_rgb = LP_BLACK;
    if (inActiveDisplay) begin
      case (r_mode)
        S_BARS: begin
          if      (w_h11 < LP_BAR1) w_rgb = 24'hFFFFFF;
          else if (w_h11 < LP_BAR2) w_rgb = 24'hFFFF00;
          else if (w_h11 < LP_BAR3) w_rgb = 24'h00FFFF;
          else if (w_h11 < LP_BAR4) w_rgb = 24'h00FF00;
          else if (w_h11 < LP_BAR5) w_rgb = 24'hFF00FF;
          else if (w_h11 < LP_BAR6) w_rgb = 24'hFF0000;
          else                      w_rgb = 24'h0000FF;
        end
        S_GRAD:  w_rgb = {hPosCounter[9:2], vPosCounter[8:1], r_frameCount};
        S_CHECK: w_rgb = (hPosCounter[5] ^ vPosCounter[5] ^ r_frameCount[5]) ? LP_WHITE : LP_BLACK;
        default: w_rgb = (w_inX && w_inY) ? LP_WHITE : LP_BLACK;
      endcase
    end
  end

  // Output register; frame-rate state moves on the same edge as frameTick
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_rgb        <= LP_BLACK;
      r_frameTick  <= 1'b0;
      r_frameCount <= 8'd0;
      r_boxX       <= 10'd0;
      r_boxY       <= 10'd0;
      r_dirX       <= 1'b1;
      r_dirY       <= 1'b1;
    end else begin
      r_rgb       <= w_rgb;
      r_frameTick <= w_tick;
      if (w_tick) begin
        r_frameCount <= r_frameCount + 8'd1;
        r_dirX       <= w_stepX[10];
        r_boxX       <= w_stepX[9:0];
        r_dirY       <= w_stepY[10];
        r_boxY       <= w_stepY[9:0];
      end
    end
  end

  assign redByte   = r_rgb[23:16];
  assign greenByte = r_rgb[15:8];
  assign blueByte  = r_rgb[7:0];
  assign modeIndex = r_mode;
  assign frameTick = r_frameTick;

endmodule
